// File: rtl/snn_pkg.sv
// rtl/snn_pkg.sv - shared types and saturating helper for the LIF spiking layer
// Purpose: FSM state enum, wide accumulator type, default V/W width typedefs and
//          the sat_add helper used by every neuron.
// Ports:   none (package).
package snn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    UPDATE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Accumulator wide enough for any realistic V_WIDTH plus a full weight sum,
  // so intermediate results never wrap before saturation.
  localparam int ACC_W = 32;
  typedef logic signed [ACC_W-1:0] acc_t;

  localparam int V_WIDTH_DEF = 16;
  localparam int W_WIDTH_DEF = 8;
  typedef logic signed [V_WIDTH_DEF-1:0] v_t;
  typedef logic signed [W_WIDTH_DEF-1:0] w_t;

  // a + b clamped to [lo, hi]; computed one bit wider so the raw sum cannot wrap.
  function automatic acc_t sat_add(input acc_t a, input acc_t b,
                                   input acc_t hi, input acc_t lo);
    logic signed [ACC_W:0] s;
    logic signed [ACC_W:0] hi_x;
    logic signed [ACC_W:0] lo_x;
    s    = $signed({a[ACC_W-1], a}) + $signed({b[ACC_W-1], b});
    hi_x = $signed({hi[ACC_W-1], hi});
    lo_x = $signed({lo[ACC_W-1], lo});
    if (s > hi_x) begin
      return hi;
    end else if (s < lo_x) begin
      return lo;
    end else begin
      return s[ACC_W-1:0];
    end
  endfunction

endpackage

// File: rtl/lif_neuron.sv
// rtl/lif_neuron.sv - one leaky integrate-and-fire neuron with spike counter
// Purpose: membrane state, leak, threshold compare, reset-on-fire and spike count.
// Ports:   clk, rst_n      clock, async active-low reset
//          clear           zero membrane, spike and count (run start)
//          update          apply one timestep using in_sum
//          in_sum          weighted input sum for this timestep (acc_t)
//          spike           registered spike of the last timestep
//          cnt             spikes fired since the last clear
module lif_neuron
  import snn_pkg::*;
#(
  parameter int V_WIDTH    = 16,
  parameter int THRESHOLD  = 64,
  parameter int LEAK_SHIFT = 3,
  parameter int RESET_MODE = 0,
  parameter int CNT_W      = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             update,
  input  acc_t             in_sum,
  output logic             spike,
  output logic [CNT_W-1:0] cnt
);

  localparam acc_t V_MAX = {{(ACC_W-V_WIDTH+1){1'b0}}, {(V_WIDTH-1){1'b1}}};
  localparam acc_t V_MIN = {{(ACC_W-V_WIDTH+1){1'b1}}, {(V_WIDTH-1){1'b0}}};
  localparam acc_t THR   = acc_t'(THRESHOLD);

  logic signed [V_WIDTH-1:0] v_q, v_d;
  logic                      spike_q, spike_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;

  acc_t v_ext, leak, v_new, v_res;
  logic fire;

  always_comb begin
    v_ext = {{(ACC_W-V_WIDTH){v_q[V_WIDTH-1]}}, v_q};
    leak  = v_ext >>> LEAK_SHIFT;
    // v - leak always stays inside the V range, so only the input sum can overflow.
    v_new = sat_add(v_ext - leak, in_sum, V_MAX, V_MIN);
    fire  = (v_new >= THR);
    v_res = (RESET_MODE == 1) ? (v_new - THR) : '0;

    v_d     = v_q;
    spike_d = spike_q;
    cnt_d   = cnt_q;
    if (clear) begin
      v_d     = '0;
      spike_d = 1'b0;
      cnt_d   = '0;
    end else if (update) begin
      spike_d = fire;
      if (fire) begin
        cnt_d = cnt_q + CNT_W'(1);
        v_d   = v_res[V_WIDTH-1:0];
      end else begin
        v_d   = v_new[V_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q     <= '0;
      spike_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      v_q     <= v_d;
      spike_q <= spike_d;
      cnt_q   <= cnt_d;
    end
  end

  assign spike = spike_q;
  assign cnt   = cnt_q;

endmodule

// File: rtl/lif_layer.sv
// rtl/lif_layer.sv - fully-connected LIF spiking layer with loadable weights
// Purpose: run control FSM, weight register file, input capture, timestep counter
//          and one lif_neuron per output.
// Ports:   clk, rst_n                clock, async active-low reset
//          start / ready             run request, accepted only while ready
//          sample / sample_ready     per-timestep input request / input valid
//          in_spikes                 input spikes captured on sample&&sample_ready
//          out_spikes                spikes of the last timestep
//          w_we / w_addr / w_data    weight write (index = out*N_IN + in), idle only
//          spike_cnt                 per-neuron spike totals, neuron 0 in LSBs
//          done                      one-cycle end-of-run pulse
module lif_layer
  import snn_pkg::*;
#(
  parameter int N_IN                = 4,
  parameter int N_OUT               = 2,
  parameter int W_WIDTH             = 8,
  parameter int V_WIDTH             = 16,
  parameter int N_CYCLES            = 10,
  parameter int CYCLES_CNT_BITWIDTH = 5,
  parameter int THRESHOLD           = 64,
  parameter int LEAK_SHIFT          = 3,
  parameter int RESET_MODE          = 0,
  localparam int AW                 = $clog2(N_IN*N_OUT)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  output logic                               ready,
  output logic                               sample,
  input  logic                               sample_ready,
  input  logic [N_IN-1:0]                    in_spikes,
  output logic [N_OUT-1:0]                   out_spikes,
  input  logic                               w_we,
  input  logic [AW-1:0]                      w_addr,
  input  logic signed [W_WIDTH-1:0]          w_data,
  output logic [N_OUT*CYCLES_CNT_BITWIDTH-1:0] spike_cnt,
  output logic                               done
);

  localparam int CW = CYCLES_CNT_BITWIDTH;

  if (CYCLES_CNT_BITWIDTH < $clog2(N_CYCLES+1)) begin : g_cnt_width_check
    $error("CYCLES_CNT_BITWIDTH too small for N_CYCLES");
  end

  state_t state_q, state_d;
  logic   init_q, init_d;
  logic [CW-1:0]   ts_q, ts_d;
  logic [N_IN-1:0] in_q, in_d;
  logic signed [W_WIDTH-1:0] w_q [N_IN*N_OUT];
  logic signed [W_WIDTH-1:0] w_d [N_IN*N_OUT];

  logic clear, update;
  acc_t sum [N_OUT];

  // init_q keeps ready low during reset and rises on the first edge after release.
  assign ready  = (state_q == IDLE) && init_q;
  assign sample = (state_q == REQ);
  assign done   = (state_q == DONE);

  assign clear  = ready && start;
  assign update = (state_q == UPDATE);

  always_comb begin
    state_d = state_q;
    init_d  = 1'b1;
    ts_d    = ts_q;
    in_d    = in_q;
    case (state_q)
      IDLE: begin
        if (clear) begin
          state_d = REQ;
          ts_d    = '0;
          in_d    = '0;
        end
      end
      REQ: begin
        if (sample_ready) begin
          in_d    = in_spikes;
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        ts_d    = ts_q + CW'(1);
        state_d = (ts_q == CW'(N_CYCLES-1)) ? DONE : REQ;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Writes land in the same edge as an accepted start, ahead of the first UPDATE.
  always_comb begin
    for (int k = 0; k < N_IN*N_OUT; k++) begin
      w_d[k] = w_q[k];
      if (ready && w_we && (w_addr == AW'(k))) begin
        w_d[k] = w_data;
      end
    end
  end

  always_comb begin
    for (int j = 0; j < N_OUT; j++) begin
      sum[j] = '0;
      for (int i = 0; i < N_IN; i++) begin
        if (in_q[i]) begin
          sum[j] = sum[j] + {{(ACC_W-W_WIDTH){w_q[j*N_IN+i][W_WIDTH-1]}}, w_q[j*N_IN+i]};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      init_q  <= 1'b0;
      ts_q    <= '0;
      in_q    <= '0;
      for (int k = 0; k < N_IN*N_OUT; k++) begin
        w_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      init_q  <= init_d;
      ts_q    <= ts_d;
      in_q    <= in_d;
      for (int k = 0; k < N_IN*N_OUT; k++) begin
        w_q[k] <= w_d[k];
      end
    end
  end

  for (genvar j = 0; j < N_OUT; j++) begin : g_neuron
    lif_neuron #(
      .V_WIDTH   (V_WIDTH),
      .THRESHOLD (THRESHOLD),
      .LEAK_SHIFT(LEAK_SHIFT),
      .RESET_MODE(RESET_MODE),
      .CNT_W     (CW)
    ) u_neuron (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (clear),
      .update(update),
      .in_sum(sum[j]),
      .spike (out_spikes[j]),
      .cnt   (spike_cnt[j*CW +: CW])
    );
  end

endmodule

// File: tb/tb_lif_layer.sv
// tb/tb_lif_layer.sv - directed self-checking bench for lif_layer (both reset modes)
module tb_lif_layer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       sample_ready = 1'b1;
  logic [3:0] in_spikes = 4'h0;
  logic       w_we = 1'b0;
  logic [2:0] w_addr = 3'd0;
  logic [7:0] w_data = 8'd0;

  logic       ready0, sample0, done0;
  logic [1:0] out0;
  logic [9:0] cnt0;
  logic       ready1, sample1, done1;
  logic [1:0] out1;
  logic [9:0] cnt1;

  int checks = 0;
  int errors = 0;
  int dc;

  always #5 clk = ~clk;

  lif_layer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ready(ready0), .sample(sample0),
    .sample_ready(sample_ready), .in_spikes(in_spikes), .out_spikes(out0),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .spike_cnt(cnt0), .done(done0)
  );

  lif_layer #(.RESET_MODE(1)) dut_r1 (
    .clk(clk), .rst_n(rst_n), .start(start), .ready(ready1), .sample(sample1),
    .sample_ready(sample_ready), .in_spikes(in_spikes), .out_spikes(out1),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .spike_cnt(cnt1), .done(done1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_w(input int a, input logic [7:0] d);
    @(negedge clk);
    w_we = 1'b1;
    w_addr = a[2:0];
    w_data = d;
    @(posedge clk);
    #1;
    w_we = 1'b0;
  endtask

  task automatic set_all(input logic [7:0] d);
    for (int k = 0; k < 8; k++) set_w(k, d);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ready"}, {31'd0, ready0}, 0);
    check({tag, "_sample"}, {31'd0, sample0}, 0);
    check({tag, "_done"}, {31'd0, done0}, 0);
    check({tag, "_out"}, {30'd0, out0}, 0);
    check({tag, "_cnt"}, {22'd0, cnt0}, 0);
    check({tag, "_cnt_r1"}, {22'd0, cnt1}, 0);
  endtask

  // One run from start; returns the cycle (start edge = cycle 0) where done is seen.
  task automatic run(input int s0, input int sl, input bit phase, input bit busy,
                     input bit ws, input logic [7:0] wd, output int dcyc);
    int n;
    @(negedge clk);
    start = 1'b1;
    if (ws) begin
      w_we = 1'b1;
      w_addr = 3'd0;
      w_data = wd;
    end
    tick();
    start = 1'b0;
    w_we = 1'b0;
    n = 1;
    dcyc = -1;
    while (n < 200) begin
      if (done0) begin
        dcyc = n;
        break;
      end
      if (phase) check("sample_phase", {31'd0, sample0}, n % 2);
      if (sl > 0 && n == s0 + sl - 1) check("stall_sample", {31'd0, sample0}, 1);
      sample_ready = (n >= s0 && n < s0 + sl) ? 1'b0 : 1'b1;
      if (busy) begin
        start = 1'b1;
        w_we = 1'b1;
        w_addr = n[2:0];
        w_data = 8'd100;
      end
      tick();
      n++;
    end
    start = 1'b0;
    w_we = 1'b0;
    sample_ready = 1'b1;
    if (dcyc < 0) check("done_timeout", 0, 1);
    tick();
    check("ready_after", {31'd0, ready0}, 1);
    check("ready_after_r1", {31'd0, ready1}, 1);
    check("done_pulse", {31'd0, done0}, 0);
  endtask

  initial begin
    // Reset state and ready rising on first edge after release
    repeat (2) @(posedge clk);
    #1;
    check_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("ready_first_edge", {31'd0, ready0}, 1);

    // All weights 20, all inputs: both neurons fire every step
    set_all(8'd20);
    in_spikes = 4'hF;
    run(0, 0, 1'b1, 1'b0, 1'b0, 8'd0, dc);
    check("t2_done_cyc", dc, 21);
    check("t2_out", {30'd0, out0}, 2'b11);
    check("t2_cnt", {22'd0, cnt0}, (10 << 5) | 10);
    check("t2_cnt_r1", {22'd0, cnt1}, (10 << 5) | 10);

    // Same, with a 5-cycle stall in timestep 3
    run(7, 5, 1'b0, 1'b0, 1'b0, 8'd0, dc);
    check("t4_done_cyc", dc, 26);
    check("t4_cnt", {22'd0, cnt0}, (10 << 5) | 10);
    check("t4_out", {30'd0, out0}, 2'b11);

    // Leak: w[0][0]=10 never reaches 64 within 10 steps
    set_all(8'd0);
    set_w(0, 8'd10);
    in_spikes = 4'h1;
    run(0, 0, 1'b0, 1'b0, 1'b0, 8'd0, dc);
    check("t3_cnt", {22'd0, cnt0}, 0);
    check("t3_out", {30'd0, out0}, 0);

    // w=11 hits exactly 64 at step 9: fire on equality
    set_w(0, 8'd11);
    run(0, 0, 1'b0, 1'b0, 1'b0, 8'd0, dc);
    check("t3b_cnt", {22'd0, cnt0}, 1);
    check("t3b_cnt_r1", {22'd0, cnt1}, 1);
    check("t3b_out", {30'd0, out0}, 0);

    // w=50 separates reset modes: mode0 fires 5 times, mode1 7 times
    set_w(0, 8'd50);
    run(0, 0, 1'b0, 1'b0, 1'b0, 8'd0, dc);
    check("t5_cnt_m0", {22'd0, cnt0}, 5);
    check("t5_cnt_m1", {22'd0, cnt1}, 7);
    check("t5_out_m1", {30'd0, out1}, 2'b01);

    // Neuron 1 only, inputs 1 and 3 at weight 20 (sum 40)
    set_w(0, 8'd0);
    for (int k = 4; k < 8; k++) set_w(k, 8'd20);
    in_spikes = 4'hA;
    run(0, 0, 1'b0, 1'b0, 1'b0, 8'd0, dc);
    check("n1_cnt_m0", {22'd0, cnt0}, 5 << 5);
    check("n1_out_m0", {30'd0, out0}, 2'b10);
    check("n1_cnt_m1", {22'd0, cnt1}, 5 << 5);
    check("n1_out_m1", {30'd0, out1}, 2'b00);

    // Reset pulsed mid-run at timestep 4
    set_all(8'd20);
    in_spikes = 4'hF;
    @(negedge clk);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    check("pre_rst_cnt", {22'd0, cnt0}, (4 << 5) | 4);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("midrst_ready", {31'd0, ready0}, 1);

    // Weights lost; writes and start during the run are dropped
    run(0, 0, 1'b0, 1'b1, 1'b0, 8'd0, dc);
    check("busy_done_cyc", dc, 21);
    check("busy_cnt", {22'd0, cnt0}, 0);
    run(0, 0, 1'b0, 1'b0, 1'b0, 8'd0, dc);
    check("dropped_w_cnt", {22'd0, cnt0}, 0);
    check("dropped_w_cnt_r1", {22'd0, cnt1}, 0);

    // start and w_we together: write lands before the first update
    in_spikes = 4'h1;
    run(0, 0, 1'b0, 1'b0, 1'b1, 8'd80, dc);
    check("sw_done_cyc", dc, 21);
    check("sw_cnt", {22'd0, cnt0}, 10);
    check("sw_cnt_r1", {22'd0, cnt1}, 10);
    check("sw_out", {30'd0, out0}, 2'b01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1, "timeout");
  end

endmodule
